// File: rtl/adbg_module_sel_ctrl.sv
// ============================================================================
// Module   : adbg_module_sel_ctrl
// Brief    : Debug-chain select controller: DR shift register, module ID,
//            select qualification/inhibit, one-hot selects and TDO mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adbg_module_sel_ctrl #(
  parameter int NB_MODULES  = 4,
  parameter int MODID_WIDTH = 5,
  parameter int SHIFT_WIDTH = 64
) (
  input  logic                   tck_i,
  input  logic                   trstn_i,
  input  logic                   debug_select_i,
  input  logic                   capture_dr_i,
  input  logic                   shift_dr_i,
  input  logic                   pause_dr_i,
  input  logic                   update_dr_i,
  input  logic                   tdi_i,
  input  logic [NB_MODULES-1:0]  module_inhibit_i,
  input  logic [NB_MODULES-1:0]  module_tdo_i,
  output logic                   tdo_o,
  output logic [SHIFT_WIDTH-1:0] data_register_o,
  output logic [NB_MODULES-1:0]  module_select_o,
  output logic [MODID_WIDTH-1:0] module_id_o,
  output logic                   select_error_o,
  output logic                   inhibit_hit_o
);

  localparam int c_cnt_width  = $clog2(SHIFT_WIDTH + 1);
  localparam int c_stat_width = MODID_WIDTH + 2;
  localparam logic [c_cnt_width-1:0] c_max_cnt  = c_cnt_width'(SHIFT_WIDTH);
  localparam logic [c_cnt_width-1:0] c_min_bits = c_cnt_width'(MODID_WIDTH + 1);
  localparam logic [MODID_WIDTH:0]   c_nb_modules = (MODID_WIDTH + 1)'(NB_MODULES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [SHIFT_WIDTH-1:0]  r_data_reg;
  logic [c_cnt_width-1:0]  r_bit_cnt;
  logic [c_stat_width-1:0] r_status;
  logic [MODID_WIDTH-1:0]  r_module_id;
  logic                    r_select_error;
  logic                    r_inhibit_hit;

  logic [MODID_WIDTH-1:0]  w_new_id;
  logic                    w_new_id_valid;
  logic                    w_id_valid;
  logic                    w_candidate;
  logic                    w_tdo;

  assign w_new_id       = r_data_reg[SHIFT_WIDTH-2 -: MODID_WIDTH];
  assign w_new_id_valid = ({1'b0, w_new_id} < c_nb_modules);
  assign w_id_valid     = ({1'b0, r_module_id} < c_nb_modules);
  // A select must carry at least the command bit plus a whole ID field.
  assign w_candidate    = ((r_state == ST_SHIFT) || (r_state == ST_PAUSE)) &&
                          r_data_reg[SHIFT_WIDTH-1] && (r_bit_cnt >= c_min_bits);

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_state        <= ST_IDLE;
      r_data_reg     <= '0;
      r_bit_cnt      <= '0;
      r_status       <= '0;
      r_module_id    <= '0;
      r_select_error <= 1'b0;
      r_inhibit_hit  <= 1'b0;
    end else if (!debug_select_i) begin
      r_state <= ST_IDLE;
    end else if (update_dr_i) begin
      r_state <= ST_IDLE;
      if (w_candidate) begin
        if (|module_inhibit_i) begin
          r_inhibit_hit <= 1'b1;
        end else begin
          r_module_id    <= w_new_id;
          r_select_error <= !w_new_id_valid;
          r_inhibit_hit  <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (capture_dr_i) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= '0;
            r_status  <= {r_inhibit_hit, r_select_error, r_module_id};
          end
        end
        ST_SHIFT: begin
          if (pause_dr_i) begin
            r_state <= ST_PAUSE;
          end else if (shift_dr_i) begin
            r_data_reg <= {tdi_i, r_data_reg[SHIFT_WIDTH-1:1]};
            r_status   <= {1'b0, r_status[c_stat_width-1:1]};
            if (r_bit_cnt != c_max_cnt) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (shift_dr_i) begin
            r_state <= ST_SHIFT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NB_MODULES; gi++) begin : g_select
      assign module_select_o[gi] = w_id_valid && (r_module_id == MODID_WIDTH'(gi));
    end
  endgenerate

  // With an invalid ID the status word is serialised instead of module data.
  always_comb begin
    w_tdo = r_status[0];
    for (int i = 0; i < NB_MODULES; i++) begin
      if (w_id_valid && (r_module_id == MODID_WIDTH'(i))) begin
        w_tdo = module_tdo_i[i];
      end
    end
  end

  assign tdo_o           = w_tdo;
  assign data_register_o = r_data_reg;
  assign module_id_o     = r_module_id;
  assign select_error_o  = r_select_error;
  assign inhibit_hit_o   = r_inhibit_hit;

endmodule

`default_nettype wire

// File: tb/tb_adbg_module_sel_ctrl.sv
// ============================================================================
// Module   : tb_adbg_module_sel_ctrl
// Brief    : Directed self-checking bench for adbg_module_sel_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adbg_module_sel_ctrl;

  logic        tck_i = 1'b0;
  logic        trstn_i = 1'b0;
  logic        debug_select_i = 1'b0;
  logic        capture_dr_i = 1'b0;
  logic        shift_dr_i = 1'b0;
  logic        pause_dr_i = 1'b0;
  logic        update_dr_i = 1'b0;
  logic        tdi_i = 1'b0;
  logic [3:0]  module_inhibit_i = 4'b0;
  logic [3:0]  module_tdo_i = 4'b0;
  logic        tdo_o;
  logic [63:0] data_register_o;
  logic [3:0]  module_select_o;
  logic [4:0]  module_id_o;
  logic        select_error_o;
  logic        inhibit_hit_o;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_reg = 64'h0;
  logic [6:0]  exp_stat;
  logic [63:0] payload;

  adbg_module_sel_ctrl #(
    .NB_MODULES (4),
    .MODID_WIDTH(5),
    .SHIFT_WIDTH(64)
  ) u_dut (
    .tck_i           (tck_i),
    .trstn_i         (trstn_i),
    .debug_select_i  (debug_select_i),
    .capture_dr_i    (capture_dr_i),
    .shift_dr_i      (shift_dr_i),
    .pause_dr_i      (pause_dr_i),
    .update_dr_i     (update_dr_i),
    .tdi_i           (tdi_i),
    .module_inhibit_i(module_inhibit_i),
    .module_tdo_i    (module_tdo_i),
    .tdo_o           (tdo_o),
    .data_register_o (data_register_o),
    .module_select_o (module_select_o),
    .module_id_o     (module_id_o),
    .select_error_o  (select_error_o),
    .inhibit_hit_o   (inhibit_hit_o)
  );

  always #5 tck_i = ~tck_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  task automatic capture();
    capture_dr_i = 1'b1;
    tick();
    capture_dr_i = 1'b0;
  endtask

  task automatic update();
    update_dr_i = 1'b1;
    tick();
    update_dr_i = 1'b0;
  endtask

  task automatic pause(input int n);
    pause_dr_i = 1'b1;
    repeat (n) tick();
    pause_dr_i = 1'b0;
  endtask

  // live=1 when the controller is expected to be in SHIFT and accept the bits
  task automatic shift_bits(input logic [63:0] d, input int n, input bit live);
    for (int i = 0; i < n; i++) begin
      shift_dr_i = 1'b1;
      tdi_i      = d[i];
      tick();
      if (live) exp_reg = {d[i], exp_reg[63:1]};
    end
    shift_dr_i = 1'b0;
    tdi_i      = 1'b0;
  endtask

  function automatic logic [63:0] mk_sel(input logic [4:0] id);
    logic [63:0] w;
    w        = 64'h0000_0000_0000_A5C3;
    w[63]    = 1'b1;
    w[62:58] = id;
    return w;
  endfunction

  task automatic sel_scan(input logic [4:0] id);
    capture();
    shift_bits(mk_sel(id), 64, 1'b1);
    update();
  endtask

  initial begin
    debug_select_i = 1'b1;
    module_tdo_i   = 4'b1010;
    repeat (3) tick();
    check("rst_data", data_register_o, 64'h0);
    check("rst_id", module_id_o, 5'd0);
    check("rst_sel", module_select_o, 4'b0001);
    check("rst_err", select_error_o, 1'b0);
    check("rst_inh", inhibit_hit_o, 1'b0);
    check("rst_tdo0", tdo_o, 1'b0);
    module_tdo_i = 4'b0001;
    #1 check("rst_tdo1", tdo_o, 1'b1);
    trstn_i = 1'b1;
    tick();

    sel_scan(5'd2);
    check("sel2_id", module_id_o, 5'd2);
    check("sel2_sel", module_select_o, 4'b0100);
    check("sel2_err", select_error_o, 1'b0);
    check("sel2_data", data_register_o, mk_sel(5'd2));
    module_tdo_i = 4'b0100;
    #1 check("sel2_tdo1", tdo_o, 1'b1);
    module_tdo_i = 4'b1011;
    #1 check("sel2_tdo0", tdo_o, 1'b0);

    sel_scan(5'd0);
    check("sel0_id", module_id_o, 5'd0);
    module_inhibit_i = 4'b0001;
    sel_scan(5'd2);
    check("inh_id", module_id_o, 5'd0);
    check("inh_hit", inhibit_hit_o, 1'b1);
    check("inh_sel", module_select_o, 4'b0001);
    module_inhibit_i = 4'b0000;
    sel_scan(5'd1);
    check("sel1_id", module_id_o, 5'd1);
    check("sel1_inh", inhibit_hit_o, 1'b0);
    check("sel1_sel", module_select_o, 4'b0010);

    sel_scan(5'd9);
    check("sel9_sel", module_select_o, 4'b0000);
    check("sel9_err", select_error_o, 1'b1);
    check("sel9_id", module_id_o, 5'd9);
    module_tdo_i = 4'b1111;
    exp_stat = 7'b0_1_01001;
    capture();
    for (int k = 0; k < 7; k++) begin
      check($sformatf("stat_bit%0d", k), tdo_o, exp_stat[k]);
      shift_bits(64'h0, 1, 1'b1);
    end
    update();
    check("stat_upd_id", module_id_o, 5'd9);
    check("stat_upd_err", select_error_o, 1'b1);

    sel_scan(5'd1);
    check("re1_err", select_error_o, 1'b0);
    capture();
    shift_bits(64'h7, 3, 1'b1);
    check("trunc_data", data_register_o, exp_reg);
    check("trunc_b63", data_register_o[63], 1'b1);
    update();
    check("trunc_id", module_id_o, 5'd1);
    check("trunc_err", select_error_o, 1'b0);
    check("trunc_sel", module_select_o, 4'b0010);

    capture();
    shift_bits(64'b10_0011, 6, 1'b1);
    update();
    check("min6_id", module_id_o, 5'd3);
    check("min6_sel", module_select_o, 4'b1000);

    payload = 64'h1234_5678_9ABC_DEF0;
    capture();
    shift_bits(payload, 64, 1'b1);
    pause(5);
    check("pause_data", data_register_o, payload);
    update();
    check("data_id", module_id_o, 5'd3);
    check("data_reg", data_register_o, payload);

    capture();
    shift_bits(64'b10_0000, 6, 1'b1);
    pause(5);
    update();
    check("pcnt_id", module_id_o, 5'd0);
    check("pcnt_sel", module_select_o, 4'b0001);

    capture_dr_i = 1'b1;
    update_dr_i  = 1'b1;
    tick();
    capture_dr_i = 1'b0;
    update_dr_i  = 1'b0;
    shift_bits(64'hFF, 8, 1'b0);
    check("capupd_data", data_register_o, exp_reg);

    debug_select_i = 1'b0;
    capture();
    shift_bits(mk_sel(5'd2), 64, 1'b0);
    update();
    debug_select_i = 1'b1;
    check("nodbg_id", module_id_o, 5'd0);
    check("nodbg_data", data_register_o, exp_reg);

    sel_scan(5'd9);
    module_tdo_i = 4'b0001;
    capture();
    shift_bits(64'hFFFFF, 20, 1'b1);
    #2 trstn_i = 1'b0;
    #1;
    check("arst_data", data_register_o, 64'h0);
    check("arst_id", module_id_o, 5'd0);
    check("arst_sel", module_select_o, 4'b0001);
    check("arst_err", select_error_o, 1'b0);
    check("arst_inh", inhibit_hit_o, 1'b0);
    check("arst_tdo", tdo_o, 1'b1);
    tick();
    trstn_i = 1'b1;
    tick();
    update();
    shift_bits(64'hFF, 8, 1'b0);
    check("post_id", module_id_o, 5'd0);
    check("post_data", data_register_o, 64'h0);
    check("post_err", select_error_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adbg_module_sel_ctrl.md
Name: adbg_module_sel_ctrl

Overview:
- JTAG-clocked select controller for the advanced debug interface; shares one DR scan chain between NB_MODULES debug sub-modules (AXI, CPU, ...).
- Owns the 64-bit input shift register and the selected-module ID, with select-command qualification and inhibit arbitration.
- Drives the one-hot module selects and the TDO multiplexer.
- Tracks the DR-scan phase in a small FSM; a bit counter rejects truncated select commands.

Parameters:
- NB_MODULES, 4: number of debug sub-modules; IDs 0..NB_MODULES-1 are valid.
- MODID_WIDTH, 5: module ID field width.
- SHIFT_WIDTH, 64: DR shift register length; bit SHIFT_WIDTH-1 is select_cmd; the ID sits directly below it.

Ports:
- tck_i  in  1  JTAG TCK; all state is clocked on its rising edge.
- trstn_i  in  1  reset, asynchronous, active-low.
- debug_select_i  in  1  debug IR selected.
- capture_dr_i  in  1  TAP Capture-DR.
- shift_dr_i  in  1  TAP Shift-DR.
- pause_dr_i  in  1  TAP Pause-DR.
- update_dr_i  in  1  TAP Update-DR.
- tdi_i  in  1  JTAG data in.
- module_inhibit_i  in  NB_MODULES  per-module request to block reselection (e.g. burst in progress).
- module_tdo_i  in  NB_MODULES  per-module TDO.
- tdo_o  out  1  muxed TDO.
- data_register_o  out  SHIFT_WIDTH  shift register contents, fanned out to all modules.
- module_select_o  out  NB_MODULES  one-hot select of the active module.
- module_id_o  out  MODID_WIDTH  current module ID.
- select_error_o  out  1  sticky: last accepted select named an invalid ID.
- inhibit_hit_o  out  1  sticky: a select was dropped because of an inhibit.

Behaviour:
- Reset values: data_register_o=0, module_id_o=0, module_select_o=1 (module 0), select_error_o=0, inhibit_hit_o=0, FSM=IDLE, bit counter=0, status register=0, tdo_o=module_tdo_i[0].
- FSM states: IDLE, SHIFT, PAUSE.
  - debug_select_i=0: FSM is held in IDLE and nothing updates.
  - IDLE->SHIFT on capture_dr_i; the bit counter clears and the status register loads {inhibit_hit_o, select_error_o, module_id_o}.
  - SHIFT->PAUSE on pause_dr_i; PAUSE->SHIFT on shift_dr_i.
  - SHIFT or PAUSE->IDLE on update_dr_i.
- Shift: in SHIFT with shift_dr_i=1:
  - data_register <= {tdi_i, data_register[SHIFT_WIDTH-1:1]}.
  - Bit counter increments, saturating at SHIFT_WIDTH.
  - Status register shifts right, filling with 0.
  - Nothing shifts in PAUSE.
- Select qualification: evaluated in the cycle update_dr_i=1. A select is a candidate if FSM is SHIFT or PAUSE, data_register[SHIFT_WIDTH-1]=1 and bit counter >= MODID_WIDTH+1. Otherwise the scan is treated as module data and no select state changes.
- Inhibit: if |module_inhibit_i is set at a candidate select, the select is dropped, module_id is unchanged and inhibit_hit_o<=1.
- Accepted select:
  - module_id_o <= data_register[SHIFT_WIDTH-2 -: MODID_WIDTH] and inhibit_hit_o<=0.
  - select_error_o <= (new ID >= NB_MODULES).
  - Selects, error flag and ID update in the same edge; they are visible the cycle after update_dr_i.
- module_select_o: one-hot of module_id_o when the ID is valid, all-zero when it is invalid. No module sees its select during an invalid ID.
- tdo_o (combinational):
  - Valid ID: module_tdo_i[module_id_o].
  - Invalid ID: status register bit 0, so the host can read the error status LSB-first after a capture.
- Simultaneous capture_dr_i and update_dr_i: illegal TAP sequence; update takes priority.
- Asynchronous reset mid-scan: everything returns to the reset values immediately; a partial select is never applied.

Test Plan:
- Reset, then a full 64-bit scan with bit63=1 and ID=2 followed by update -> module_select_o=4'b0100, module_id_o=2, select_error_o=0; tdo_o follows module_tdo_i[2].
- Select ID=2 while module_inhibit_i=4'b0001 -> module_id_o stays at its prior value 0, inhibit_hit_o=1. Next select of ID=1 with no inhibit -> inhibit_hit_o=0, module_select_o=4'b0010.
- Select ID=9 -> module_select_o=0, select_error_o=1. Next capture plus 7 shifts -> tdo_o serialises status 7'b0_1_01001 LSB-first.
- Only 3 bits shifted, then update with data_register[63]=1 -> counter too low, no select change.
- Scan with bit63=0 -> module_id_o unchanged, data_register_o holds the shifted payload; a pause mid-scan (pause_dr_i for 5 cycles) preserves the register and counter.
- trstn_i low after 20 shift bits -> all outputs return to reset values asynchronously; subsequent update_dr_i has no effect, because FSM=IDLE.
